// File: rtl/cp0_reg.sv
// CP0 register file: Count/Compare timer, Status, Cause, EPC, PRId.
// Serves mtc0/mfc0 from EX and records exception entry/return state.
//
// Ports:
//   clk, rst          core clock; asynchronous active-low reset
//   we/waddr/wdata    mtc0 write port
//   raddr/rdata       mfc0 read port (combinational, write-forwarded)
//   int_i             level-sensitive hardware interrupt lines
//   excptype_i/pc_i   exception request and faulting PC from EX
//   count_o ..epc_o   architectural register views
//   timer_int_o       sticky timer interrupt flag
//   int_pending_o     unmasked interrupt pending
module cp0_reg #(
   parameter logic [31:0] PRID_VALUE = 32'h0001_0100,
   parameter bit          TIMER_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   input  logic [5:0]  int_i,
   input  logic [31:0] excptype_i,
   input  logic [31:0] pc_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic        timer_int_o,
   output logic        int_pending_o
);

   localparam logic [4:0] R_COUNT   = 5'd9;
   localparam logic [4:0] R_COMPARE = 5'd11;
   localparam logic [4:0] R_STATUS  = 5'd12;
   localparam logic [4:0] R_CAUSE   = 5'd13;
   localparam logic [4:0] R_EPC     = 5'd14;
   localparam logic [4:0] R_PRID    = 5'd15;

   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic [31:0] status_q;
   logic [31:0] epc_q;
   logic [5:0]  hw_q;
   logic [1:0]  ip_q;
   logic [4:0]  exc_q;
   logic        timer_q;
   logic [31:0] cause_w;

   logic exc_any;
   logic sw_we;
   logic is_int;
   logic is_sys;
   logic is_eret;
   logic timer_hit;
   logic wr_count;
   logic wr_compare;
   logic wr_status;
   logic wr_cause;
   logic wr_epc;

   assign exc_any = |excptype_i;
   // Any exception request, even an unknown code, drops the mtc0.
   assign sw_we   = we & ~exc_any;
   assign is_int  = (excptype_i == 32'h1);
   assign is_sys  = (excptype_i == 32'h8);
   assign is_eret = (excptype_i == 32'he);

   assign wr_count   = sw_we & (waddr == R_COUNT);
   assign wr_compare = sw_we & (waddr == R_COMPARE);
   assign wr_status  = sw_we & (waddr == R_STATUS);
   assign wr_cause   = sw_we & (waddr == R_CAUSE);
   assign wr_epc     = sw_we & (waddr == R_EPC);

   assign timer_hit = TIMER_EN
                    & (count_q == compare_q)
                    & (compare_q != 32'h0);

   assign cause_w = {16'h0, hw_q, ip_q, 1'b0, exc_q, 2'b00};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= 32'h0;
         compare_q <= 32'h0;
         status_q  <= 32'h1000_0000;
         epc_q     <= 32'h0;
         hw_q      <= 6'h0;
         ip_q      <= 2'h0;
         exc_q     <= 5'h0;
         timer_q   <= 1'b0;
      end else begin
         if (wr_count) count_q <= wdata;
         else          count_q <= count_q + 32'd1;

         // Compare write beats a same-cycle match.
         if (wr_compare) begin
            compare_q <= wdata;
            timer_q   <= 1'b0;
         end else if (timer_hit) begin
            timer_q   <= 1'b1;
         end

         hw_q <= {int_i[5] | timer_q, int_i[4:0]};

         if (wr_cause) ip_q <= wdata[9:8];

         if (is_int | is_sys) begin
            status_q[1] <= 1'b1;
            exc_q       <= is_sys ? 5'd8 : 5'd0;
            // Nested exception keeps the outer EPC.
            if (!status_q[1]) epc_q <= pc_i;
         end else if (is_eret) begin
            status_q[1] <= 1'b0;
         end else begin
            if (wr_status) status_q <= wdata;
            if (wr_epc)    epc_q    <= wdata;
         end
      end
   end

   always_comb begin
      rdata = 32'h0;
      case (raddr)
         R_COUNT:   rdata = count_q;
         R_COMPARE: rdata = compare_q;
         R_STATUS:  rdata = status_q;
         R_CAUSE:   rdata = cause_w;
         R_EPC:     rdata = epc_q;
         R_PRID:    rdata = PRID_VALUE;
         default:   rdata = 32'h0;
      endcase
      if (sw_we && (waddr == raddr)) begin
         case (raddr)
            R_COUNT,
            R_COMPARE,
            R_STATUS,
            R_EPC:   rdata = wdata;
            R_CAUSE: rdata = {cause_w[31:10],
                              wdata[9:8],
                              cause_w[7:0]};
            default: ;
         endcase
      end
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign status_o    = status_q;
   assign cause_o     = cause_w;
   assign epc_o       = epc_q;
   assign timer_int_o = timer_q;
   assign int_pending_o = status_q[0] & ~status_q[1]
                        & |(cause_w[15:8] & status_q[15:8]);

endmodule

// File: tb/tb_cp0_reg.sv
// Testbench for cp0_reg: reference model plus directed vectors.
// Model state is updated per clock; outputs compared every negedge.
module tb_cp0_reg;

   localparam logic [31:0] PRID = 32'h0001_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  raddr = '0;
   logic [31:0] rdata;
   logic [5:0]  int_i = '0;
   logic [31:0] excptype_i = '0;
   logic [31:0] pc_i = '0;
   logic [31:0] count_o, compare_o, status_o, cause_o, epc_o;
   logic        timer_int_o, int_pending_o;

   int n_checks = 0;
   int n_fail   = 0;

   cp0_reg #(.PRID_VALUE(PRID), .TIMER_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata),
      .int_i(int_i), .excptype_i(excptype_i), .pc_i(pc_i),
      .count_o(count_o), .compare_o(compare_o),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
      .timer_int_o(timer_int_o), .int_pending_o(int_pending_o)
   );

   always #5 clk = ~clk;

   // Reference model: architectural registers held as plain values.
   logic [31:0] m_count   = 0;
   logic [31:0] m_compare = 0;
   logic [31:0] m_status  = 32'h1000_0000;
   logic [31:0] m_epc     = 0;
   logic [5:0]  m_hw      = 0;
   logic [1:0]  m_ip      = 0;
   logic [4:0]  m_code    = 0;
   logic        m_timer   = 0;

   function automatic logic [31:0] m_cause();
      return {16'h0, m_hw, m_ip, 1'b0, m_code, 2'b00};
   endfunction

   function automatic logic m_pend();
      logic [31:0] c;
      c = m_cause();
      return m_status[0] && !m_status[1]
             && ((c[15:8] & m_status[15:8]) != 0);
   endfunction

   function automatic logic [31:0] m_read();
      logic [31:0] v;
      logic [31:0] c;
      c = m_cause();
      case (raddr)
         9:  v = m_count;
         11: v = m_compare;
         12: v = m_status;
         13: v = c;
         14: v = m_epc;
         15: v = PRID;
         default: v = 0;
      endcase
      if (we && waddr == raddr && excptype_i == 0) begin
         if (raddr == 9 || raddr == 11 || raddr == 12 || raddr == 14)
            v = wdata;
         else if (raddr == 13)
            v = (c & ~32'h300) | (wdata & 32'h300);
      end
      return v;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
         m_epc = 0; m_hw = 0; m_ip = 0; m_code = 0; m_timer = 0;
      end else begin
         logic sw;
         logic hit;
         logic [31:0] nc;
         sw  = we && (excptype_i == 0);
         hit = (m_count == m_compare) && (m_compare != 0);
         nc  = (sw && waddr == 9) ? wdata : m_count + 1;
         m_hw = {int_i[5] | m_timer, int_i[4:0]};
         if (sw && waddr == 11) begin
            m_compare = wdata;
            m_timer = 0;
         end else if (hit) begin
            m_timer = 1;
         end
         m_count = nc;
         if (sw && waddr == 13) m_ip = wdata[9:8];
         if (sw && waddr == 12) m_status = wdata;
         if (sw && waddr == 14) m_epc = wdata;
         if (excptype_i == 1 || excptype_i == 8) begin
            if (!m_status[1]) m_epc = pc_i;
            m_status[1] = 1;
            m_code = (excptype_i == 8) ? 5'd8 : 5'd0;
         end else if (excptype_i == 32'he) begin
            m_status[1] = 0;
         end
      end
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("count",   count_o,   m_count);
      chk("compare", compare_o, m_compare);
      chk("status",  status_o,  m_status);
      chk("cause",   cause_o,   m_cause());
      chk("epc",     epc_o,     m_epc);
      chk("timer",   {31'h0, timer_int_o}, {31'h0, m_timer});
      chk("pending", {31'h0, int_pending_o}, {31'h0, m_pend()});
      chk("rdata",   rdata,     m_read());
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we = 1; waddr = a; wdata = d;
      step();
      we = 0;
   endtask

   initial begin
      rst = 1'b0;
      #12;
      chk("rst_count", count_o, 32'h0);
      chk("rst_status", status_o, 32'h1000_0000);
      @(posedge clk); #2;
      rst = 1'b1;
      // 1: run to 5, then reset pulse between edges
      repeat (5) step();
      chk("count5", count_o, 32'd5);
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      chk("async_count",  count_o, 32'h0);
      chk("async_status", status_o, 32'h1000_0000);
      chk("async_cause",  cause_o, 32'h0);
      chk("async_epc",    epc_o, 32'h0);
      chk("async_timer",  {31'h0, timer_int_o}, 32'h0);
      #1;
      rst = 1'b1;
      #1;
      chk("restart0", count_o, 32'h0);
      step();
      chk("restart1", count_o, 32'd1);
      // 2: Compare=10 written at Count=3
      step(); step();
      chk("count3", count_o, 32'd3);
      wr(11, 32'd10);
      for (int i = 0; i < 20 && count_o != 10; i++) step();
      chk("reach10", count_o, 32'd10);
      chk("no_timer_yet", {31'h0, timer_int_o}, 32'h0);
      step();
      chk("timer_set", {31'h0, timer_int_o}, 32'h1);
      step();
      chk("cause15", {31'h0, cause_o[15]}, 32'h1);
      wr(11, 32'd20);
      chk("timer_clr", {31'h0, timer_int_o}, 32'h0);
      // 3: syscall then eret
      excptype_i = 32'h8; pc_i = 32'h40;
      step();
      excptype_i = 0;
      chk("sys_epc", epc_o, 32'h40);
      chk("sys_exl", {31'h0, status_o[1]}, 32'h1);
      chk("sys_code", {27'h0, cause_o[6:2]}, 32'd8);
      excptype_i = 32'he;
      step();
      excptype_i = 0;
      chk("eret_exl", {31'h0, status_o[1]}, 32'h0);
      chk("eret_epc", epc_o, 32'h40);
      // 4: nested interrupt with dropped EPC write
      excptype_i = 32'h8; pc_i = 32'h40;
      step();
      excptype_i = 32'h1; pc_i = 32'h80;
      we = 1; waddr = 14; wdata = 32'hDEAD; raddr = 14;
      #1;
      chk("exc_nofwd", rdata, 32'h40);
      step();
      we = 0; excptype_i = 0;
      chk("nest_epc", epc_o, 32'h40);
      chk("nest_code", {27'h0, cause_o[6:2]}, 32'd0);
      excptype_i = 32'he;
      step();
      // unknown code: write still dropped
      excptype_i = 32'h3;
      we = 1; waddr = 14; wdata = 32'hBEEF;
      step();
      we = 0; excptype_i = 0;
      chk("unk_epc", epc_o, 32'h40);
      // 5: forwarding and write masks
      we = 1; waddr = 14; wdata = 32'h1234; raddr = 14;
      #1;
      chk("fwd_epc", rdata, 32'h1234);
      step();
      waddr = 15; wdata = 32'hFFFF_FFFF; raddr = 15;
      #1;
      chk("prid_ro", rdata, PRID);
      step();
      waddr = 13; wdata = 32'hFFFF_FFFF; raddr = 13;
      step();
      we = 0;
      chk("cause_ip", {30'h0, cause_o[9:8]}, 32'h3);
      chk("cause_lo", {24'h0, cause_o[7:0]}, 32'h0);
      chk("cause_hi", {16'h0, cause_o[31:16]}, 32'h0);
      // 6: Count wrap, hw interrupt, pending mask
      wr(9, 32'hFFFF_FFFF);
      chk("cnt_max", count_o, 32'hFFFF_FFFF);
      step();
      chk("cnt_wrap", count_o, 32'h0);
      int_i = 6'b000001;
      step();
      chk("cause10", {31'h0, cause_o[10]}, 32'h1);
      chk("pend_off", {31'h0, int_pending_o}, 32'h0);
      wr(12, 32'h0000_0401);
      chk("pend_on", {31'h0, int_pending_o}, 32'h1);
      wr(12, 32'h0000_0400);
      chk("pend_ie0", {31'h0, int_pending_o}, 32'h0);
      int_i = 0;
      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
